// File: rtl/ram_arbiter.sv
// Two-requester front end for the single-port synchronous RAM. It clears the
// RAM after reset, then round-robins the port between A and B and returns read data.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rsp_valid,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  init_done,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    prio_b_q, prio_b_d;   // 1: B wins a tie
  logic                    a_rsp_q, a_rsp_d;
  logic                    b_rsp_q, b_rsp_d;
  logic                    init_done_q, init_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   din_q;

  // Handshake: a request transfers in any cycle where x_valid && x_ready.
  // x_ready is the combinational grant and may depend on x_valid; a requester
  // must hold its request stable while valid is high and ready is low, and
  // must take read data in the single cycle its x_rsp_valid is high.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_b_d    = prio_b_q;
    a_rsp_d     = 1'b0;
    b_rsp_d     = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_q;
    ram_din     = din_q;
    init_done_d = (state_q == ST_RUN);
    case (state_q)
      ST_WAIT: begin
        ram_addr = '0;
        ram_din  = '0;
        state_d  = ST_INIT;
      end
      ST_INIT: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        ram_din  = '0;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        a_ready = a_valid & (~b_valid | ~prio_b_q);
        b_ready = b_valid & (~a_valid | prio_b_q);
        if (a_ready) begin
          ram_we   = a_we;
          ram_addr = a_addr;
          ram_din  = a_wdata;
          a_rsp_d  = ~a_we;
          prio_b_d = 1'b1;
        end else if (b_ready) begin
          ram_we   = b_we;
          ram_addr = b_addr;
          ram_din  = b_wdata;
          b_rsp_d  = ~b_we;
          prio_b_d = 1'b0;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // addr_q/din_q remember the last value driven so an idle RUN cycle holds the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      prio_b_q    <= 1'b0;
      a_rsp_q     <= 1'b0;
      b_rsp_q     <= 1'b0;
      init_done_q <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_b_q    <= prio_b_d;
      a_rsp_q     <= a_rsp_d;
      b_rsp_q     <= b_rsp_d;
      init_done_q <= init_done_d;
      addr_q      <= ram_addr;
      din_q       <= ram_din;
    end
  end

  assign a_rsp_valid = a_rsp_q;
  assign b_rsp_valid = b_rsp_q;
  assign rsp_rdata   = ram_dout;
  assign init_done   = init_done_q;
  assign dbg_state   = state_q;

endmodule
